// File: rtl/csi_tx_phy_dat.sv
// D-PHY/CSI-2 transmit data-lane sequencer: turns a valid/ready byte stream into
// a full HS burst (LP-01, LP-00, HS-zero, sync, payload, trail, LP-11) for an 8:1 serializer.
module csi_tx_phy_dat #(
  parameter bit INVERT       = 1'b0,
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 4,
  parameter int T_HS_TRAIL   = 3
) (
  input  logic       byte_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] hs_byte,
  output logic       hs_en,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       busy,
  output logic       underflow
);

  localparam int MAX_A = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
  localparam int MAX_B = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] LPX_LOAD   = CW'(T_LPX - 1);
  localparam logic [CW-1:0] PREP_LOAD  = CW'(T_HS_PREPARE - 1);
  localparam logic [CW-1:0] ZERO_LOAD  = CW'(T_HS_ZERO - 1);
  localparam logic [CW-1:0] TRAIL_LOAD = CW'(T_HS_TRAIL - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [7:0]    SYNC_BYTE  = 8'hB8;

  typedef enum logic [2:0] {
    IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    raw, raw_d;
  logic          ready_d, uf_d;
  logic          lp_p_d, lp_n_d;

  // raw holds the non-inverted lane byte so the trail level is derived from the
  // true last payload bit regardless of board polarity.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    raw_d   = raw;
    ready_d = 1'b0;
    uf_d    = 1'b0;
    unique case (state)
      IDLE: begin
        raw_d = 8'h00;
        if (enable && tx_valid) begin
          state_d = LPX;
          cnt_d   = LPX_LOAD;
        end
      end
      LPX: begin
        if (cnt == '0) begin
          state_d = PREP;
          cnt_d   = PREP_LOAD;
        end else cnt_d = cnt - CNT_ONE;
      end
      PREP: begin
        if (cnt == '0) begin
          state_d = ZERO;
          cnt_d   = ZERO_LOAD;
        end else cnt_d = cnt - CNT_ONE;
      end
      ZERO: begin
        if (cnt == '0) begin
          state_d = SYNC;
          raw_d   = SYNC_BYTE;
          ready_d = 1'b1;
        end else cnt_d = cnt - CNT_ONE;
      end
      SYNC, DATA: begin
        // tx_ready low in DATA means the last byte is on the lane this cycle
        if (tx_ready && tx_valid) begin
          state_d = DATA;
          raw_d   = tx_data;
          ready_d = ~tx_last;
        end else begin
          state_d = TRAIL;
          cnt_d   = TRAIL_LOAD;
          raw_d   = {8{~raw[7]}};
          uf_d    = tx_ready;
        end
      end
      TRAIL: begin
        if (cnt == '0) begin
          state_d = EXIT;
          cnt_d   = LPX_LOAD;
          raw_d   = 8'h00;
        end else cnt_d = cnt - CNT_ONE;
      end
      EXIT: begin
        if (cnt == '0) state_d = IDLE;
        else cnt_d = cnt - CNT_ONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        raw_d   = 8'h00;
      end
    endcase
  end

  assign lp_p_d = (state_d == IDLE) || (state_d == EXIT);
  assign lp_n_d = (state_d == IDLE) || (state_d == EXIT) || (state_d == LPX);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      raw       <= 8'h00;
      hs_byte   <= {8{INVERT}};
      hs_en     <= 1'b0;
      lp_dp     <= 1'b1;
      lp_dn     <= 1'b1;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      raw       <= raw_d;
      hs_byte   <= raw_d ^ {8{INVERT}};
      hs_en     <= (state_d == ZERO) || (state_d == SYNC) ||
                   (state_d == DATA) || (state_d == TRAIL);
      lp_dp     <= INVERT ? lp_n_d : lp_p_d;
      lp_dn     <= INVERT ? lp_p_d : lp_n_d;
      tx_ready  <= ready_d;
      busy      <= (state_d != IDLE);
      underflow <= uf_d;
    end
  end

endmodule

// File: tb/tb_csi_tx_phy_dat.sv
// Directed bench: a normal and a P/N-swapped lane driven by one stream, checked
// cycle by cycle against hand-computed burst waveforms.
module tb_csi_tx_phy_dat;

  logic       byte_clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;

  logic       tx_ready, hs_en, lp_dp, lp_dn, busy, underflow;
  logic [7:0] hs_byte;
  logic       tx_ready_i, hs_en_i, lp_dp_i, lp_dn_i, busy_i, underflow_i;
  logic [7:0] hs_byte_i;

  int errors = 0;
  int checks = 0;

  logic [7:0] pkt [4];
  int pkt_n = 0;
  int pkt_send = 0;
  int pkt_idx = 0;

  always #5 byte_clock = ~byte_clock;

  csi_tx_phy_dat #(.INVERT(1'b0)) dut (
    .byte_clock(byte_clock), .reset(reset), .enable(enable),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .hs_byte(hs_byte), .hs_en(hs_en),
    .lp_dp(lp_dp), .lp_dn(lp_dn), .busy(busy), .underflow(underflow)
  );

  csi_tx_phy_dat #(.INVERT(1'b1)) dut_inv (
    .byte_clock(byte_clock), .reset(reset), .enable(enable),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready_i), .hs_byte(hs_byte_i), .hs_en(hs_en_i),
    .lp_dp(lp_dp_i), .lp_dn(lp_dn_i), .busy(busy_i), .underflow(underflow_i)
  );

  task automatic loadPacket(input logic [7:0] b0, b1, b2, b3, input int n, input int send);
    pkt[0] = b0; pkt[1] = b1; pkt[2] = b2; pkt[3] = b3;
    pkt_n = n; pkt_send = send; pkt_idx = 0;
    tx_valid = (send > 0);
    tx_data  = b0;
    tx_last  = (n == 1);
  endtask

  // One clock: the source advances to its next byte only after a handshake edge.
  task automatic applyStimulus();
    logic accept;
    accept = tx_ready && tx_valid;
    @(posedge byte_clock);
    #1;
    if (accept) begin
      pkt_idx++;
      if (pkt_idx < pkt_send) begin
        tx_data = pkt[pkt_idx];
        tx_last = (pkt_idx == pkt_n - 1);
      end else begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
      end
    end
  endtask

  // Expectations are given for the normal lane; the swapped lane must show the
  // complemented byte and exchanged LP levels with identical control outputs.
  task automatic checkOutput(input string tag, input logic [7:0] eb, input logic en,
                             input logic dp, input logic dn, input logic rdy,
                             input logic bsy, input logic uf);
    logic [12:0] exp_n, exp_i, obs_n, obs_i;
    exp_n = {eb, en, dp, dn, rdy, bsy, uf};
    exp_i = {~eb, en, dn, dp, rdy, bsy, uf};
    obs_n = {hs_byte, hs_en, lp_dp, lp_dn, tx_ready, busy, underflow};
    obs_i = {hs_byte_i, hs_en_i, lp_dp_i, lp_dn_i, tx_ready_i, busy_i, underflow_i};
    checks++;
    assert (obs_n === exp_n) else begin
      errors++;
      $error("[TB] FAIL %s normal observed=%h expected=%h", tag, obs_n, exp_n);
    end
    checks++;
    assert (obs_i === exp_i) else begin
      errors++;
      $error("[TB] FAIL %s inverted observed=%h expected=%h", tag, obs_i, exp_i);
    end
  endtask

  task automatic step(input string tag, input int reps, input logic [7:0] eb, input logic en,
                      input logic dp, input logic dn, input logic rdy,
                      input logic bsy, input logic uf);
    for (int r = 0; r < reps; r++) begin
      applyStimulus();
      checkOutput(tag, eb, en, dp, dn, rdy, bsy, uf);
    end
  endtask

  // LP-01 x2, LP-00 x2, HS-zero x4, sync with ready
  task automatic preamble(input string tag);
    step({tag, "_lpx"},  2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step({tag, "_prep"}, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step({tag, "_zero"}, 4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step({tag, "_sync"}, 1, 8'hB8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    $display("[TB] csi_tx_phy_dat directed run");
    repeat (2) @(posedge byte_clock);
    #1;
    checkOutput("reset_values", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("idle_no_valid", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Packet A: 00 03 06; enable drops mid-burst without effect
    enable = 1'b1;
    loadPacket(8'h00, 8'h03, 8'h06, 8'h00, 3, 3);
    preamble("pktA");
    step("pktA_d0", 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    enable = 1'b0;
    step("pktA_d1", 1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pktA_d2_last", 1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktA_trail", 3, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktA_exit", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("pktA_idle", 1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Valid without enable must not start a burst
    loadPacket(8'h80, 8'h00, 8'h00, 8'h00, 1, 1);
    step("idle_enable_low", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Packet B: single byte 0x80, trail drives zeros
    enable = 1'b1;
    preamble("pktB");
    step("pktB_d0_last", 1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktB_trail", 3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktB_exit", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("pktB_idle", 1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Packet C: 4 bytes announced, source starves after 2
    loadPacket(8'h91, 8'h25, 8'h33, 8'h44, 4, 2);
    preamble("pktC");
    step("pktC_d0", 1, 8'h91, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pktC_d1", 1, 8'h25, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pktC_underflow", 1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    loadPacket(8'h33, 8'h44, 8'h55, 8'h00, 3, 3);
    step("pktC_trail", 2, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktC_exit", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("pktC_idle", 1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Packet D: the unconsumed 0x33 starts a fresh burst, then reset mid-DATA
    preamble("pktD");
    step("pktD_d0", 1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pktD_d1", 1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_data", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("reset_held", 1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Packet E: full preamble again after reset; last byte 0x7E gives 0xFF trail
    loadPacket(8'hC0, 8'h7E, 8'h00, 8'h00, 2, 2);
    preamble("pktE");
    step("pktE_d0", 1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pktE_d1_last", 1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktE_trail", 3, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pktE_exit", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("pktE_idle", 2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
